// File: rtl/nn_out_pkg.sv
// Shared types and constants for the network output classifier stage.
package nn_out_pkg;

  localparam int M_OUT = 10;
  localparam int WIDTH = 16;
  localparam int IDX_W = 4;

  typedef logic signed [WIDTH-1:0] score_t;
  typedef logic        [IDX_W-1:0] idx_t;

  typedef enum logic {
    COLLECT = 1'b0,
    OUTPUT  = 1'b1
  } state_t;

endpackage

// File: rtl/argmax_cmp_16.sv
// Combinational compare-and-select: strict signed greater-than keeps the lowest index on ties.
module argmax_cmp_16 #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic                    first,
  input  logic signed [WIDTH-1:0] score,
  input  logic signed [WIDTH-1:0] max_cur,
  input  logic        [IDX_W-1:0] idx_cur,
  input  logic        [IDX_W-1:0] count,
  output logic signed [WIDTH-1:0] max_nxt,
  output logic        [IDX_W-1:0] idx_nxt
);
  logic take;

  // The first element of a vector always loads, whatever stale max_r holds.
  assign take    = first || (score > max_cur);
  assign max_nxt = take ? score : max_cur;
  assign idx_nxt = take ? count : idx_cur;

endmodule

// File: rtl/argmax_out_10_16.sv
// Output classifier: tracks the running max over an M-score vector, then presents index/value.
//  state   | meaning
//  COLLECT | accepting scores, s_ready_x=1, m_valid_y=0
//  OUTPUT  | result held until m_ready_y, s_ready_x=0, m_valid_y=1
module argmax_out_10_16 #(
  parameter int M     = 10,
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s_data_in_x,
  input  logic             s_valid_x,
  output logic             s_ready_x,
  output logic [IDX_W-1:0] m_idx_y,
  output logic [WIDTH-1:0] m_max_y,
  output logic             m_valid_y,
  input  logic             m_ready_y
);
  import nn_out_pkg::*;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(M - 1);

  state_t                    state, state_nxt;
  logic        [IDX_W-1:0]   count;
  logic signed [WIDTH-1:0]   max_r, max_nxt;
  logic        [IDX_W-1:0]   idx_r, idx_nxt;
  logic                      in_fire;

  assign s_ready_x = (state == COLLECT);
  assign m_valid_y = (state == OUTPUT);
  assign in_fire   = s_valid_x && s_ready_x;
  assign m_idx_y   = idx_r;
  assign m_max_y   = max_r;

  argmax_cmp_16 #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_cmp (
    .first   (count == '0),
    .score   (s_data_in_x),
    .max_cur (max_r),
    .idx_cur (idx_r),
    .count   (count),
    .max_nxt (max_nxt),
    .idx_nxt (idx_nxt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (in_fire && count == LAST) state_nxt = OUTPUT;
      OUTPUT:  if (m_ready_y)                state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= COLLECT;
      count <= '0;
      max_r <= '0;
      idx_r <= '0;
    end else begin
      state <= state_nxt;
      if (in_fire) begin
        max_r <= max_nxt;
        idx_r <= idx_nxt;
        count <= (count == LAST) ? '0 : count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_argmax_out_10_16.sv
// Directed bench for argmax_out_10_16: vector table plus backpressure, gap and reset sequences.
module tb_argmax_out_10_16;

  typedef struct {
    logic signed [15:0] s [10];
    logic        [3:0]  idx;
    logic signed [15:0] mx;
  } vec_t;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] s_data_in_x;
  logic               s_valid_x;
  logic               s_ready_x;
  logic        [3:0]  m_idx_y;
  logic signed [15:0] m_max_y;
  logic               m_valid_y;
  logic               m_ready_y;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  vec_t tbl [7];

  argmax_out_10_16 dut (
    .clk         (clk),
    .reset       (reset),
    .s_data_in_x (s_data_in_x),
    .s_valid_x   (s_valid_x),
    .s_ready_x   (s_ready_x),
    .m_idx_y     (m_idx_y),
    .m_max_y     (m_max_y),
    .m_valid_y   (m_valid_y),
    .m_ready_y   (m_ready_y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feeds one vector; leaves the DUT in OUTPUT when rdy=0, otherwise completes the output handshake.
  task automatic send_vec(input vec_t v, input bit gaps, input bit rdy, input string nm);
    int t0;
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      s_data_in_x = v.s[i];
      s_valid_x   = 1'b1;
      chk({nm, ".valid_low"}, int'(m_valid_y), 0);
      tick();
      if (gaps && i < 9) begin
        s_valid_x   = 1'b0;
        s_data_in_x = 16'sh7FFF;
        tick();
      end
    end
    // Upstream keeps offering a large score during OUTPUT; it must not be consumed.
    s_data_in_x = 16'sh7FFF;
    s_valid_x   = 1'b1;
    m_ready_y   = rdy;
    chk({nm, ".valid"}, int'(m_valid_y), 1);
    chk({nm, ".ready_low"}, int'(s_ready_x), 0);
    chk({nm, ".idx"}, int'(m_idx_y), int'(v.idx));
    chk({nm, ".max"}, int'(m_max_y), int'(v.mx));
    if (rdy) begin
      tick();
      s_valid_x = 1'b0;
      chk({nm, ".valid_drop"}, int'(m_valid_y), 0);
      chk({nm, ".ready_back"}, int'(s_ready_x), 1);
      if (!gaps) chk({nm, ".cycles"}, cyc - t0, 11);
    end
  endtask

  initial begin
    tbl[0].s = '{16'sd5, -16'sd3, 16'sd12, 16'sd7, 16'sd0, 16'sd1, 16'sd2, 16'sd3, 16'sd4, -16'sd8};
    tbl[0].idx = 4'd2; tbl[0].mx = 16'sd12;
    for (int i = 0; i < 10; i++) tbl[1].s[i] = 16'sh8000;
    tbl[1].idx = 4'd0; tbl[1].mx = 16'sh8000;
    tbl[2].s = '{16'sd1, 16'sd2, 16'sd3, 16'sd9, -16'sd5, 16'sd0, 16'sd4, 16'sd9, 16'sd8, -16'sd1};
    tbl[2].idx = 4'd3; tbl[2].mx = 16'sd9;
    for (int i = 0; i < 9; i++) tbl[3].s[i] = -16'sd1;
    tbl[3].s[9] = 16'sd100;
    tbl[3].idx = 4'd9; tbl[3].mx = 16'sd100;
    for (int i = 0; i < 10; i++) tbl[4].s[i] = 16'sh8000;
    tbl[4].s[0] = 16'sh7FFF; tbl[4].s[5] = 16'sh7FFF;
    tbl[4].idx = 4'd0; tbl[4].mx = 16'sh7FFF;
    for (int i = 0; i < 10; i++) tbl[5].s[i] = 16'(-10 + i);
    tbl[5].idx = 4'd9; tbl[5].mx = -16'sd1;
    for (int i = 0; i < 10; i++) tbl[6].s[i] = 16'(100 - 10 * i);
    tbl[6].idx = 4'd0; tbl[6].mx = 16'sd100;

    reset       = 1'b0;
    s_valid_x   = 1'b0;
    s_data_in_x = '0;
    m_ready_y   = 1'b0;
    #12;
    chk("rst.valid", int'(m_valid_y), 0);
    chk("rst.idx", int'(m_idx_y), 0);
    chk("rst.max", int'(m_max_y), 0);
    @(negedge clk) reset = 1'b1;
    tick();
    chk("rst.ready", int'(s_ready_x), 1);

    // Back-to-back streaming of every table vector with the consumer always ready.
    m_ready_y = 1'b1;
    for (int k = 0; k < 7; k++) send_vec(tbl[k], 1'b0, 1'b1, $sformatf("vec%0d", k));

    // Valid toggling every cycle.
    send_vec(tbl[3], 1'b1, 1'b1, "gaps");

    // Backpressure: six stall cycles with upstream valid held high.
    send_vec(tbl[0], 1'b0, 1'b0, "bp");
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("bp.hold_valid", int'(m_valid_y), 1);
      chk("bp.hold_ready", int'(s_ready_x), 0);
      chk("bp.hold_idx", int'(m_idx_y), 2);
      chk("bp.hold_max", int'(m_max_y), 12);
    end
    m_ready_y = 1'b1;
    tick();
    s_valid_x = 1'b0;
    chk("bp.release_valid", int'(m_valid_y), 0);
    chk("bp.release_ready", int'(s_ready_x), 1);
    send_vec(tbl[6], 1'b0, 1'b1, "bp.next");

    // Reset mid-vector after four scores, including a dominant 1000 at index 1.
    for (int i = 0; i < 4; i++) begin
      s_data_in_x = (i == 1) ? 16'sd1000 : 16'sd0;
      s_valid_x   = 1'b1;
      tick();
    end
    s_valid_x = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rstmid.valid", int'(m_valid_y), 0);
    chk("rstmid.ready", int'(s_ready_x), 1);
    @(negedge clk) reset = 1'b1;
    tick();
    send_vec(tbl[5], 1'b0, 1'b1, "rstmid.fresh");

    // Reset while a result is pending: m_valid_y must drop without a clock edge.
    send_vec(tbl[2], 1'b0, 1'b0, "rstout");
    s_valid_x = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rstout.valid", int'(m_valid_y), 0);
    chk("rstout.idx", int'(m_idx_y), 0);
    chk("rstout.max", int'(m_max_y), 0);
    @(negedge clk) reset = 1'b1;
    tick();
    chk("rstout.ready", int'(s_ready_x), 1);
    m_ready_y = 1'b1;
    send_vec(tbl[0], 1'b0, 1'b1, "rstout.fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
